// File: rtl/logic_analyzer_pkg.sv
// Shared types and constants for the serial-frame logic analyzer:
// command codes, readout state encoding and the UART byte width.
package logic_analyzer_pkg;

    localparam int UART_BYTE_W  = 8;
    localparam int STATUS_BYTES = 3;

    typedef enum logic [4:0] {
        LA_CLEAR       = 5'd0,
        LA_READ_ALL    = 5'd1,
        LA_READ_STATUS = 5'd2
    } la_commands_e;

    typedef enum logic [2:0] {
        RD_IDLE  = 3'd0,
        RD_FETCH = 3'd1,
        RD_LOAD  = 3'd2,
        RD_WAIT1 = 3'd3,
        RD_WAIT2 = 3'd4,
        RD_SEND  = 3'd5
    } rd_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/logic_analyzer_serial_capture_if.sv
// Host-side bundle: command strobe from the device controller and the
// byte handshake towards the UART transmitter.
interface logic_analyzer_serial_capture_if;
    import logic_analyzer_pkg::*;

    logic                   dev_command_started;
    logic [4:0]             dev_command;
    logic                   dev_busy;
    logic                   uart_tx_send_byte;
    logic [UART_BYTE_W-1:0] uart_tx_byte;
    logic                   uart_tx_active;

    modport master (
        output dev_command_started, dev_command, uart_tx_active,
        input  dev_busy, uart_tx_send_byte, uart_tx_byte
    );

    modport slave (
        input  dev_command_started, dev_command, uart_tx_active,
        output dev_busy, uart_tx_send_byte, uart_tx_byte
    );

endinterface

// File: rtl/logic_analyzer_serial_capture_fifo.sv
// Synchronous frame FIFO with registered read data (1-cycle latency) and
// flush. A write into a full FIFO is accepted only when a read happens too.
module la_sync_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 64
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   wr_req,
    input  logic                   rd_req,
    input  logic [WIDTH-1:0]       data,
    output logic [WIDTH-1:0]       q,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             wr_ok_s, rd_ok_s;

    assign full  = (count_q == CNT_MAX);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign q     = q_q;

    // Pointer, occupancy and read-data next-state; flush overrides traffic.
    always_comb begin
        rd_ok_s  = rd_req && !empty;
        wr_ok_s  = wr_req && (!full || rd_ok_s);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        q_d      = q_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_ok_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (rd_ok_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
                q_d      = mem_q[rd_ptr_q];
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({wr_ok_s, rd_ok_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            q_q      <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            q_q      <= q_d;
        end
    end

    // Storage array; a same-edge read of the written slot returns the old word.
    always_ff @(posedge clock) begin
        if (wr_ok_s && !flush) begin
            mem_q[wr_ptr_q] <= data;
        end
    end

endmodule

// File: rtl/logic_analyzer_serial_capture.sv
// Serial-frame logic analyzer: synchronises an external clock/data pair,
// captures start-bit framed words into a FIFO and streams them over a UART.
module logic_analyzer_serial_capture
    import logic_analyzer_pkg::*;
#(
    parameter int FRAME_BITS    = 48,
    parameter int FIFO_DEPTH    = 64,
    parameter int SYNC_STAGES   = 2,
    parameter int SAMPLE_RISING = 1,
    parameter int IDLE_TIMEOUT  = 4096
) (
    input  logic                            clock,
    input  logic                            reset_n,
    logic_analyzer_serial_capture_if.slave  host,
    output logic                            led_full,
    input  logic                            logic_clock,
    input  logic                            logic_serial
);
    localparam int BYTES_PER_FRAME = FRAME_BITS / 8;
    localparam int SR_W  = (FRAME_BITS > 24) ? FRAME_BITS : 24;
    localparam int IDX_W = $clog2(FRAME_BITS);
    localparam int TO_W  = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT + 1) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int BC_W  = $clog2(SR_W / 8 + 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);
    localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(IDLE_TIMEOUT);
    localparam logic [BC_W-1:0]  BC_ONE   = BC_W'(1);

    logic [SYNC_STAGES-1:0] lclk_sync_q, lclk_sync_d, lser_sync_q, lser_sync_d;
    logic                   lclk_prev_q, lclk_prev_d;
    logic                   lclk_cur_s, sample_edge_s, sample_bit_s;
    logic                   capturing_q, capturing_d, prev_ser_q, prev_ser_d;
    logic                   push_q, push_d;
    logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
    logic [FRAME_BITS-1:0]  frame_q, frame_d;
    logic [TO_W-1:0]        timer_q, timer_d;
    logic [7:0]             ovf_cnt_q, ovf_cnt_d;
    logic                   ovf_flag_q, ovf_flag_d;
    logic                   clear_s, pop_s, drop_s;

    rd_state_e              state_q, state_d;
    logic                   mode_status_q, mode_status_d;
    logic [BC_W-1:0]        bytes_left_q, bytes_left_d;
    logic [SR_W-1:0]        shift_q, shift_d;
    logic                   send_q, send_d, busy_q, busy_d, led_q, led_d;
    logic [UART_BYTE_W-1:0] byte_q, byte_d;

    logic [FRAME_BITS-1:0]  fifo_q_s;
    logic                   fifo_full_s, fifo_empty_s;
    logic [CNT_W-1:0]       fifo_count_s;
    logic [15:0]            frame_cnt16_s;

    assign lclk_cur_s    = lclk_sync_q[SYNC_STAGES-1];
    assign sample_bit_s  = lser_sync_q[SYNC_STAGES-1];
    assign sample_edge_s = (SAMPLE_RISING != 0) ? (lclk_cur_s && !lclk_prev_q)
                                                : (!lclk_cur_s && lclk_prev_q);
    assign clear_s       = host.dev_command_started && (host.dev_command == LA_CLEAR);
    assign frame_cnt16_s = 16'(fifo_count_s);
    assign drop_s        = push_q && fifo_full_s && !pop_s && !clear_s;

    la_sync_fifo #(.WIDTH(FRAME_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .flush   (clear_s),
        .wr_req  (push_q),
        .rd_req  (pop_s),
        .data    (frame_q),
        .q       (fifo_q_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .count   (fifo_count_s)
    );

    // Input synchronisers, frame capture, timeout and overflow accounting.
    always_comb begin
        lclk_sync_d = {lclk_sync_q[SYNC_STAGES-2:0], logic_clock};
        lser_sync_d = {lser_sync_q[SYNC_STAGES-2:0], logic_serial};
        lclk_prev_d = lclk_cur_s;
        capturing_d = capturing_q;
        bit_idx_d   = bit_idx_q;
        frame_d     = frame_q;
        timer_d     = timer_q;
        push_d      = 1'b0;
        prev_ser_d  = sample_edge_s ? sample_bit_s : prev_ser_q;
        if (clear_s) begin
            capturing_d = 1'b0;
            timer_d     = '0;
        end else if (capturing_q) begin
            if (sample_edge_s) begin
                frame_d[bit_idx_q] = sample_bit_s;
                timer_d            = '0;
                if (bit_idx_q == '0) begin
                    capturing_d = 1'b0;
                    push_d      = 1'b1;
                end else begin
                    bit_idx_d = bit_idx_q - IDX_ONE;
                end
            end else if ((IDLE_TIMEOUT != 0) && (timer_q == TO_LIMIT)) begin
                capturing_d = 1'b0;
                timer_d     = '0;
            end else begin
                timer_d = timer_q + TO_ONE;
            end
        end else if (sample_edge_s && prev_ser_q && !sample_bit_s) begin
            capturing_d             = 1'b1;
            frame_d[FRAME_BITS-1]   = 1'b0;
            bit_idx_d               = IDX_W'(FRAME_BITS - 2);
            timer_d                 = '0;
        end else begin
            capturing_d = capturing_q;
        end

        if (clear_s) begin
            ovf_cnt_d  = 8'd0;
            ovf_flag_d = 1'b0;
        end else if (drop_s) begin
            ovf_cnt_d  = sat_inc8(ovf_cnt_q);
            ovf_flag_d = 1'b1;
        end else begin
            ovf_cnt_d  = ovf_cnt_q;
            ovf_flag_d = ovf_flag_q;
        end
        led_d = fifo_full_s || ovf_flag_q;
    end

    // Capture-side registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lclk_sync_q <= '0;
            lser_sync_q <= '0;
            lclk_prev_q <= 1'b0;
            capturing_q <= 1'b0;
            prev_ser_q  <= 1'b0;
            push_q      <= 1'b0;
            bit_idx_q   <= '0;
            frame_q     <= '0;
            timer_q     <= '0;
            ovf_cnt_q   <= 8'd0;
            ovf_flag_q  <= 1'b0;
            led_q       <= 1'b0;
        end else begin
            lclk_sync_q <= lclk_sync_d;
            lser_sync_q <= lser_sync_d;
            lclk_prev_q <= lclk_prev_d;
            capturing_q <= capturing_d;
            prev_ser_q  <= prev_ser_d;
            push_q      <= push_d && !clear_s;
            bit_idx_q   <= bit_idx_d;
            frame_q     <= frame_d;
            timer_q     <= timer_d;
            ovf_cnt_q   <= ovf_cnt_d;
            ovf_flag_q  <= ovf_flag_d;
            led_q       <= led_d;
        end
    end

    // Readout FSM: the WAIT states give the UART time to raise uart_tx_active.
    always_comb begin
        state_d       = state_q;
        mode_status_d = mode_status_q;
        bytes_left_d  = bytes_left_q;
        shift_d       = shift_q;
        byte_d        = byte_q;
        send_d        = 1'b0;
        pop_s         = 1'b0;
        if (clear_s) begin
            state_d = RD_IDLE;
        end else begin
            case (state_q)
                RD_IDLE: begin
                    if (host.dev_command_started && (host.dev_command == LA_READ_ALL)) begin
                        mode_status_d = 1'b0;
                        state_d       = RD_FETCH;
                    end else if (host.dev_command_started && (host.dev_command == LA_READ_STATUS)) begin
                        mode_status_d = 1'b1;
                        shift_d       = SR_W'({ovf_cnt_q, frame_cnt16_s});
                        bytes_left_d  = BC_W'(STATUS_BYTES);
                        state_d       = RD_SEND;
                    end else begin
                        state_d = RD_IDLE;
                    end
                end
                RD_FETCH: begin
                    if (fifo_empty_s) begin
                        state_d = RD_IDLE;
                    end else begin
                        pop_s        = 1'b1;
                        bytes_left_d = '0;
                        state_d      = RD_LOAD;
                    end
                end
                RD_LOAD: begin
                    shift_d      = SR_W'(fifo_q_s);
                    bytes_left_d = BC_W'(BYTES_PER_FRAME);
                    state_d      = RD_SEND;
                end
                RD_SEND: begin
                    if (host.uart_tx_active) begin
                        state_d = RD_SEND;
                    end else if (bytes_left_q != '0) begin
                        byte_d       = shift_q[UART_BYTE_W-1:0];
                        send_d       = 1'b1;
                        shift_d      = shift_q >> UART_BYTE_W;
                        bytes_left_d = bytes_left_q - BC_ONE;
                        state_d      = RD_WAIT1;
                    end else if (mode_status_q) begin
                        state_d = RD_IDLE;
                    end else begin
                        state_d = RD_FETCH;
                    end
                end
                RD_WAIT1: state_d = RD_WAIT2;
                RD_WAIT2: state_d = RD_SEND;
                default:  state_d = RD_IDLE;
            endcase
        end
        busy_d = (state_d != RD_IDLE);
    end

    // Readout registers and registered host outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= RD_IDLE;
            mode_status_q <= 1'b0;
            bytes_left_q  <= '0;
            shift_q       <= '0;
            byte_q        <= '0;
            send_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_status_q <= mode_status_d;
            bytes_left_q  <= bytes_left_d;
            shift_q       <= shift_d;
            byte_q        <= byte_d;
            send_q        <= send_d;
            busy_q        <= busy_d;
        end
    end

    assign host.dev_busy          = busy_q;
    assign host.uart_tx_send_byte = send_q;
    assign host.uart_tx_byte      = byte_q;
    assign led_full               = led_q;

endmodule
